mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive data-port grants while the fetch port is waiting.
REQ-002 clock  input  1  system clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 if_req  input  1  fetch port request; held high with if_addr stable until if_valid.
REQ-005 if_addr  input  32  fetch address.
REQ-006 if_rdata  output  32  fetch read data; meaningful while if_valid=1.
REQ-007 if_valid  output  1  one-cycle completion pulse for the fetch port.
REQ-008 dm_req  input  1  data port request; held high with dm_we/dm_addr/dm_wdata stable until dm_valid.
REQ-009 dm_we  input  1  1=write, 0=read.
REQ-010 dm_addr  input  32  data address.
REQ-011 dm_wdata  input  32  write data.
REQ-012 dm_rdata  output  32  data read data; meaningful while dm_valid=1 and the access was a read.
REQ-013 dm_valid  output  1  one-cycle completion pulse for the data port.
REQ-014 mem_ren  output  1  memory read enable.
REQ-015 mem_wen  output  1  memory write enable.
REQ-016 mem_addr  output  32  memory address.
REQ-017 mem_din  output  32  memory write data.
REQ-018 mem_dout  input  32  combinational memory read data.
REQ-019 addr_err  output  1  sticky flag: a granted address had bits [31:12] nonzero.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, ACCESS, DONE.
REQ-021 IDLE: if no request, stay; otherwise arbitrate, latch the winner's port id, we, addr and wdata, then go to ACCESS.
REQ-022 Arbitration SHALL be data-priority: dm_req wins over if_req unless starve_cnt==STARVE_LIMIT, in which case the fetch port wins.
REQ-023 starve_cnt SHALL increment on each data grant made while if_req=1, clear on any fetch grant, clear in any IDLE cycle with if_req=0, and saturate at STARVE_LIMIT.
REQ-024 The fetch port SHALL always be treated as a read; if_req never produces mem_wen.
REQ-025 mem_ren/mem_wen SHALL be registered and high only during the single ACCESS cycle: mem_ren for reads, mem_wen for writes, never both.
REQ-026 mem_addr and mem_din SHALL drive the latched values from the ACCESS cycle until the next grant; mem_din SHALL be 0 for fetch grants.
REQ-027 ACCESS SHALL last exactly one cycle; on its closing edge a read captures mem_dout into the winner's rdata register, and the FSM goes to DONE.
REQ-028 DONE: mem_ren=mem_wen=0 (turnaround cycle); the winner's valid SHALL be 1 for exactly this cycle; next state IDLE.
REQ-029 if_rdata/dm_rdata SHALL hold their last captured value until the next read on that port; writes leave dm_rdata unchanged.
REQ-030 Requests are not sampled in ACCESS or DONE; a req still high in the IDLE cycle after valid is a new request.
REQ-031 Latency from req high in IDLE to valid SHALL be 2 cycles; throughput SHALL be one access per 3 cycles.
REQ-032 addr_err SHALL be set on the edge entering ACCESS when the latched addr[31:12]!=0; the access still proceeds using addr unchanged.
REQ-033 Request inputs SHALL be ignored while reset=1.

Reset
REQ-034 On a clock edge with reset=1: state=IDLE, mem_ren=mem_wen=0, if_valid=dm_valid=0, starve_cnt=0, addr_err=0, mem_addr=mem_din=0, if_rdata=dm_rdata=0.
REQ-035 Reset asserted during ACCESS or DONE SHALL abandon the transfer: no valid pulse is issued, and enables are 0 from the next edge.

Verification
REQ-036 Single fetch: if_req=1, if_addr=0x10, memory word 0x10=0xDEADBEEF -> mem_ren high in cycle 1 only; if_valid=1 and if_rdata=0xDEADBEEF in cycle 2.
REQ-037 Write then read: dm write 0x20<=0x12345678, then dm read 0x20 -> mem_wen one cycle, mem_ren never together with it, dm_rdata=0x12345678 on the second dm_valid.
REQ-038 Simultaneous if_req and dm_req in IDLE -> data granted first (dm_valid at cycle 2), fetch served next (if_valid at cycle 5).
REQ-039 Starvation: dm_req and if_req held continuously, STARVE_LIMIT=4 -> grant sequence D,D,D,D,F,D,D,D,D,F.
REQ-040 Reset mid-ACCESS of a dm write -> no dm_valid, mem_wen=0 after the reset edge, state IDLE, all outputs at reset values.
REQ-041 dm read at 0x00001000 -> addr_err=1 from the ACCESS cycle onward and held until reset; dm_valid still pulses.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a fetch port and a data port onto one single-cycle memory.
// Data port has priority; a saturating counter bounds how long fetch can be starved.
module mem_arbiter #(
    parameter  int unsigned STARVE_LIMIT = 4,
    localparam int unsigned AW = 32,
    localparam int unsigned DW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_valid,
    output logic          mem_ren,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          addr_err
);

    localparam int unsigned CW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_DM = 1'b1
    } port_t;

    state_t        state_q, state_d;
    port_t         port_q, port_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          mem_ren_q, mem_ren_d;
    logic          mem_wen_q, mem_wen_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_din_q, mem_din_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          if_valid_q, if_valid_d;
    logic          dm_valid_q, dm_valid_d;
    logic          addr_err_q, addr_err_d;
    logic          fetch_win_c;
    logic [AW-1:0] gnt_addr_c;

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        starve_cnt_d = starve_cnt_q;
        mem_ren_d    = 1'b0;
        mem_wen_d    = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        if_valid_d   = 1'b0;
        dm_valid_d   = 1'b0;
        addr_err_d   = addr_err_q;
        fetch_win_c  = if_req && (!dm_req || (starve_cnt_q == CW'(STARVE_LIMIT)));
        gnt_addr_c   = fetch_win_c ? if_addr : dm_addr;

        case (state_q)
            IDLE: begin
                if (!if_req) begin
                    starve_cnt_d = '0;
                end
                if (if_req || dm_req) begin
                    mem_addr_d = gnt_addr_c;
                    if (fetch_win_c) begin
                        port_d       = PORT_IF;
                        mem_din_d    = '0;
                        mem_ren_d    = 1'b1;
                        starve_cnt_d = '0;
                    end else begin
                        port_d    = PORT_DM;
                        mem_din_d = dm_wdata;
                        mem_ren_d = !dm_we;
                        mem_wen_d = dm_we;
                        if (if_req && (starve_cnt_q != CW'(STARVE_LIMIT))) begin
                            starve_cnt_d = starve_cnt_q + CW'(1);
                        end
                    end
                    // Out-of-range addresses are flagged but still issued unchanged.
                    if (gnt_addr_c[AW-1:12] != '0) begin
                        addr_err_d = 1'b1;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ren_q) begin
                    if (port_q == PORT_IF) begin
                        if_rdata_d = mem_dout;
                    end else begin
                        dm_rdata_d = mem_dout;
                    end
                end
                if_valid_d = (port_q == PORT_IF);
                dm_valid_d = (port_q == PORT_DM);
                state_d    = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            port_q       <= PORT_IF;
            starve_cnt_q <= '0;
            mem_ren_q    <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            if_valid_q   <= 1'b0;
            dm_valid_q   <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            starve_cnt_q <= starve_cnt_d;
            mem_ren_q    <= mem_ren_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            if_valid_q   <= if_valid_d;
            dm_valid_q   <= dm_valid_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign if_rdata = if_rdata_q;
    assign if_valid = if_valid_q;
    assign dm_rdata = dm_rdata_q;
    assign dm_valid = dm_valid_q;
    assign mem_ren  = mem_ren_q;
    assign mem_wen  = mem_wen_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign addr_err = addr_err_q;

endmodule
